xcvr_tx_width_down_converter: RTL



---
 rtl/xcvr_tx_width_down_converter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/xcvr_tx_width_down_converter.sv
// xcvr_tx_width_down_converter
// ----------------------------------------------------------------------------
// Buffers wide pattern-generator words (RATIO x OUT_W bits) and serialises
// each one into RATIO narrow lanes for the transceiver TX parallel interface.
// In free-run mode the consumer is treated as always ready and IDLE_WORD is
// emitted whenever the buffer runs dry; each such idle lane is counted.
//
// Ports:
//   clk, reset_n    single clock, asynchronous active-low reset
//   in_data/valid   wide word from the pattern generator
//   in_ready        buffer can accept (not full)
//   out_data/valid  registered narrow lane towards the XCVR
//   out_ready       consumer accepts out_data (ignored while free_run=1)
//   free_run        always-read consumer emulation with idle insertion
//   clr_cnt         synchronous clear of underflow_cnt
//   empty, full     registered buffer status
//   fill_level      words currently held (an entry stays until its last lane)
//   underflow_cnt   saturating count of idle lanes emitted
// ----------------------------------------------------------------------------
module xcvr_tx_width_down_converter #(
    parameter int               OUT_W     = 64,
    parameter int               RATIO     = 2,
    parameter int               DEPTH     = 4,
    parameter int               MSB_FIRST = 0,
    parameter logic [OUT_W-1:0] IDLE_WORD = '0,
    parameter int               CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [RATIO*OUT_W-1:0]     in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       free_run,
    input  logic                       clr_cnt,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [CNT_W-1:0]           underflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef logic [RATIO-1:0][OUT_W-1:0] word_t;

    word_t            mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      fill_level_r;
    logic             empty_r;
    logic             full_r;
    logic [LW-1:0]    lane_ptr_r;
    logic [OUT_W-1:0] out_data_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] underflow_cnt_r;

    logic             push_s;
    logic             load_en_s;
    logic             last_lane_s;
    logic             pop_s;
    logic             idle_s;
    logic [LW-1:0]    lane_sel_s;
    logic [AW:0]      fill_next_s;
    word_t            head_word_s;

    // Handshake decode, lane selection and next fill level.
    always_comb begin
        push_s      = in_valid && !full_r;  // no pass-through: full blocks even with a pop
        load_en_s   = !out_valid_r || out_ready || free_run;
        last_lane_s = (lane_ptr_r == LW'(RATIO - 1));
        pop_s       = load_en_s && !empty_r && last_lane_s;
        idle_s      = load_en_s && empty_r && free_run;
        lane_sel_s  = (MSB_FIRST != 0) ? (LW'(RATIO - 1) - lane_ptr_r) : lane_ptr_r;
        head_word_s = mem_r[rd_ptr_r];
        fill_next_s = fill_level_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end

    // Word storage; data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Buffer pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fill_level_r <= '0;
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            fill_level_r <= fill_next_s;
            empty_r      <= (fill_next_s == '0);
            full_r       <= (fill_next_s == (AW+1)'(DEPTH));
        end
    end

    // Output lane register; empty implies lane_ptr==0, so idles land on word boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            lane_ptr_r  <= '0;
        end else if (load_en_s) begin
            if (!empty_r) begin
                out_data_r  <= head_word_s[lane_sel_s];
                out_valid_r <= 1'b1;
                lane_ptr_r  <= last_lane_s ? '0 : lane_ptr_r + LW'(1);
            end else if (free_run) begin
                out_data_r  <= IDLE_WORD;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Saturating idle-lane counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_cnt_r <= '0;
        end else if (clr_cnt) begin
            underflow_cnt_r <= '0;
        end else if (idle_s && (underflow_cnt_r != '1)) begin
            underflow_cnt_r <= underflow_cnt_r + CNT_W'(1);
        end
    end

    assign in_ready      = !full_r;
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign empty         = empty_r;
    assign full          = full_r;
    assign fill_level    = fill_level_r;
    assign underflow_cnt = underflow_cnt_r;

endmodule
